dshot_rx: RTL

Receive-side DSHOT150 frame decoder. It samples a single DSHOT motor line, classifies each bit by its high-pulse width, assembles the 16-bit frame, and checks the 4-bit CRC. Decoded throttle and telemetry values are presented with a one-cycle valid strobe. It is the receiving end of the flight-controller DSHOT output and is used in two places: an ESC-side loopback check on `o_motorN` inside the FPGA, and as a synthesizable scoreboard in design-level benches.

---
 rtl/dshot_pkg.sv | 30 +++
 rtl/sync_edge.sv | 30 +++
 rtl/dshot_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/dshot_pkg.sv
// rtl/dshot_pkg.sv - DSHOT150 shared types, nominal timing and CRC helper
package dshot_pkg;

    localparam int DSHOT150_BIT_CYCLES = 480;
    localparam int DSHOT150_T0H_CYCLES = 180;
    localparam int DSHOT150_T1H_CYCLES = 360;
    localparam int DSHOT150_THRESH_CYCLES = 270;
    localparam int DSHOT150_MIN_HIGH_CYCLES = 60;
    localparam int DSHOT150_MAX_HIGH_CYCLES = 450;
    localparam int DSHOT150_GAP_CYCLES = 960;

    typedef struct packed {
        logic [10:0] throttle;
        logic        telemetry;
        logic [3:0]  crc;
    } dshot_frame_t;

    typedef enum logic [2:0] {
        ST_RECOVER,
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_CHECK
    } dshot_state_t;

    function automatic logic [3:0] dshot_crc(logic [11:0] v);
        return v[3:0] ^ v[7:4] ^ v[11:8];
    endfunction

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - 2-flop synchronizer with registered rise/fall detect
module sync_edge (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [2:0] sh_q;
    logic [2:0] sh_d;

    always_comb begin
        sh_d = {sh_q[1:0], i_d};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_q <= 3'b000;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign o_level = sh_q[1];
    assign o_rise  = sh_q[1] & ~sh_q[2];
    assign o_fall  = ~sh_q[1] & sh_q[2];

endmodule

// File: rtl/dshot_rx.sv
// rtl/dshot_rx.sv - DSHOT150 receiver: pulse-width bit decode, framing and CRC check
module dshot_rx
    import dshot_pkg::*;
#(
    parameter int BIT_CYCLES      = DSHOT150_BIT_CYCLES,
    parameter int THRESH_CYCLES   = DSHOT150_THRESH_CYCLES,
    parameter int MIN_HIGH_CYCLES = DSHOT150_MIN_HIGH_CYCLES,
    parameter int MAX_HIGH_CYCLES = DSHOT150_MAX_HIGH_CYCLES,
    parameter int GAP_CYCLES      = DSHOT150_GAP_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_dshot,
    output logic [15:0] o_frame,
    output logic [10:0] o_throttle,
    output logic        o_telemetry,
    output logic        o_valid,
    output logic        o_crc_err,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int CW = $clog2(GAP_CYCLES + 1);

    logic line, rise, fall;

    sync_edge u_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_dshot),
        .o_level (line),
        .o_rise  (rise),
        .o_fall  (fall)
    );

    dshot_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   shift_q, shift_d;
    logic [3:0]    idx_q, idx_d;
    dshot_frame_t  frame_q, frame_d;
    logic          valid_q, valid_d;
    logic          crc_err_q, crc_err_d;
    logic          frame_err_q, frame_err_d;
    logic          busy_q, busy_d;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        frame_d     = frame_q;
        valid_d     = 1'b0;
        crc_err_d   = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_RECOVER: begin
                if (!line && cnt_q >= CW'(GAP_CYCLES)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (rise) begin
                    idx_d   = 4'd15;
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (cnt_q > CW'(MAX_HIGH_CYCLES)) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_RECOVER;
                end else if (fall) begin
                    if (cnt_q < CW'(MIN_HIGH_CYCLES)) begin
                        frame_err_d = 1'b1;
                        state_d     = ST_RECOVER;
                    end else begin
                        shift_d = {shift_q[14:0], cnt_q >= CW'(THRESH_CYCLES)};
                        if (idx_q == 4'd0) begin
                            state_d = ST_CHECK;
                        end else begin
                            idx_d   = idx_q - 4'd1;
                            state_d = ST_LOW;
                        end
                    end
                end
            end
            ST_LOW: begin
                if (cnt_q >= CW'(GAP_CYCLES)) begin
                    frame_err_d = 1'b1;
                    state_d     = ST_RECOVER;
                end else if (rise) begin
                    state_d = ST_HIGH;
                end
            end
            ST_CHECK: begin
                if (dshot_crc(shift_q[15:4]) == shift_q[3:0]) begin
                    frame_d = shift_q;
                    valid_d = 1'b1;
                end else begin
                    crc_err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_RECOVER;
        endcase

        // Entering RECOVER after an error demands a fresh full gap of low line.
        if (state_d == ST_RECOVER && state_q != ST_RECOVER) begin
            cnt_d = '0;
        end else if (rise || fall) begin
            cnt_d = CW'(1);
        end else if (state_q == ST_RECOVER && line) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(GAP_CYCLES)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        busy_d = (state_d == ST_HIGH) || (state_d == ST_LOW);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_RECOVER;
            cnt_q       <= '0;
            shift_q     <= '0;
            idx_q       <= '0;
            frame_q     <= '0;
            valid_q     <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            frame_q     <= frame_d;
            valid_q     <= valid_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign o_frame     = frame_q;
    assign o_throttle  = frame_q.throttle;
    assign o_telemetry = frame_q.telemetry;
    assign o_valid     = valid_q;
    assign o_crc_err   = crc_err_q;
    assign o_frame_err = frame_err_q;
    assign o_busy      = busy_q;

endmodule
